// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// RISC-V funct3 access codes and the two-bit access-size codes.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // funct3 encodings of the load/store instructions
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size is funct3[1:0]; anything other than byte/half is a word
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit: store byte enables and
// lane replication from the incoming request, plus load byte/half selection
// and sign/zero extension from the latched request and the memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic        st_we,
  input  logic [31:0] st_wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store lanes: loads read the full word; a half ignores addr[0]
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    be        = 4'b1111;
    wdata_rep = '0;
    if (st_we) begin
      case (st_size)
        SZ_B: begin
          be        = 4'b0001 << st_off;
          wdata_rep = {4{st_wdata[7:0]}};
        end
        SZ_H: begin
          be        = 4'b0011 << {st_off[1], 1'b0};
          wdata_rep = {2{st_wdata[15:0]}};
        end
        default: begin
          be        = 4'b1111;
          wdata_rep = st_wdata;
        end
      endcase
    end
  end

  // Load extraction: pick the addressed byte/half, then extend
  always_comb begin
    byte_sel = ld_word[{ld_off, 3'b000} +: 8];
    half_sel = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_funct3)
      F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ld_data = {24'b0, byte_sel};
      F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ld_data = {16'b0, half_sel};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: IDLE/WAIT/DONE handshake FSM with timeout, stalling the
// core until a byte/half/word access to the backing memory completes.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned accesses abort
// with err instead of being silently aligned down).
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  tcnt;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] ld_data_c;
  logic        misaligned;

  lsu_align u_align (
    .st_size   (funct3[1:0]),
    .st_off    (addr[1:0]),
    .st_we     (req_we),
    .st_wdata  (wdata),
    .be        (be_c),
    .wdata_rep (wdata_c),
    .ld_funct3 (funct3_q),
    .ld_off    (off_q),
    .ld_word   (mem_rdata),
    .ld_data   (ld_data_c)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  // Misalignment check on the incoming request
  always_comb begin
    case (funct3[1:0])
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = addr[0];
      default: misaligned = |addr[1:0];
    endcase
  end
`else
  // Without the trap, misaligned accesses are aligned down by the lane logic
  assign misaligned = 1'b0;
`endif

  // mem_req follows state only, so it drops the instant reset lands in WAIT.
  // stall must be combinational from req_valid to freeze the PC in the
  // request cycle itself.
  assign mem_req = (state == WAIT);
  assign stall   = !reset && ((state == IDLE && req_valid) || state == WAIT);

  // Handshake FSM with timeout counter and registered memory/result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tcnt      <= '0;
      funct3_q  <= '0;
      off_q     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      case (state)
        IDLE: begin
          if (req_valid) begin
            funct3_q <= funct3;
            off_q    <= addr[1:0];
            tcnt     <= '0;
            mem_addr <= {addr[31:2], 2'b00};
            if (misaligned) begin
              // Abort without touching memory
              mem_we    <= 1'b0;
              mem_be    <= '0;
              mem_wdata <= '0;
              rdata     <= '0;
              err       <= 1'b1;
              state     <= DONE;
            end else begin
              mem_we    <= req_we;
              mem_be    <= be_c;
              mem_wdata <= wdata_c;
              state     <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_ready) begin
            rdata <= mem_we ? '0 : ld_data_c;
            err   <= 1'b0;
            state <= DONE;
          end else if (tcnt == TCNT_LAST) begin
            rdata <= '0;
            err   <= 1'b1;
            state <= DONE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        DONE: begin
          // Results are valid for the DONE cycle only
          rdata <= '0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the single-cycle datapath: it consumes the ALU address and register store data, performs a byte/half/word access to a backing data memory over a req/ready handshake, and returns aligned, sign- or zero-extended load data to the result mux. Because the backing memory may take several cycles, the unit stalls the core's PC and register write until the access completes.

## Interface
- `TIMEOUT`, default 16: maximum cycles to wait for `mem_ready` before aborting with an error; legal range 1..255.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  current instruction is a load or store.
- `req_we`  in  1  1 = store, 0 = load.
- `funct3`  in  3  access size and sign: LB=000, LH=001, LW=010, LBU=100, LHU=101; stores use 000/001/010.
- `addr`  in  32  byte address (ALU result).
- `wdata`  in  32  store data (rs2), LSB-justified.
- `stall`  out  1  hold PC and suppress RegWrite this cycle.
- `rdata`  out  32  extended load data, valid in DONE.
- `err`  out  1  access aborted (timeout or misalignment), valid in DONE.
- `mem_req`  out  1  memory request, held until ready.
- `mem_we`  out  1  memory write.
- `mem_addr`  out  32  word address, `addr & ~3`.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ready`  in  1  memory accepts/completes the request this cycle.
- `mem_rdata`  in  32  read word, valid when `mem_ready`.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: if `req_valid`, latch `addr`, `funct3`, `req_we`, `wdata`; assert `stall`; go to WAIT (or to DONE with `err`=1 on misalignment, see Configuration). Otherwise `stall`=0.
- WAIT: `mem_req`=1, `stall`=1, memory outputs driven from latched values and held stable. On `mem_ready`: capture extended load data (loads only), go to DONE. Each WAIT cycle without `mem_ready` increments the timeout counter; when the counter reaches `TIMEOUT`, drop `mem_req` and go to DONE with `err`=1, `rdata`=0.
- DONE: `stall`=0, `rdata`/`err` valid for exactly this cycle; the core commits and advances. Next state is always IDLE; `req_valid` is not sampled in DONE.
- Byte lanes: SB → `mem_be` = 0001 << addr[1:0], `wdata[7:0]` replicated ×4; SH → 0011 << addr[1:0], `wdata[15:0]` replicated ×2; SW → 1111. Loads drive `mem_be`=1111.
- Load extraction: select byte/half by addr[1:0], sign-extend for LB/LH, zero-extend for LBU/LHU. funct3 011, 110, 111 are treated as LW.
- Misaligned: half with addr[0]=1; word with addr[1:0]≠0.

## Timing
- Reset values: state IDLE, `stall`=0, `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0, `rdata`=0, `err`=0, counter 0.
- Best-case latency: request cycle (IDLE) + 1 WAIT cycle with `mem_ready` + DONE = 3 cycles per memory instruction; each extra WAIT cycle adds 1.
- `mem_req` rises the cycle after the IDLE request and is combinationally from state, not from `req_valid`.
- `mem_ready` outside WAIT is ignored.
- Reset mid-WAIT: `mem_req` drops immediately; the memory must tolerate an abandoned request.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a misaligned request skips WAIT, goes straight to DONE with `err`=1, `rdata`=0, and no memory access (a store writes nothing).
- Not defined: no detection; a misaligned half is treated as aligned to addr[1] (addr[0] ignored), and a word as aligned to the word boundary; `err` is asserted only on timeout.

## Structure
- `lsu_pkg`: state enum (IDLE/WAIT/DONE), funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
- Sub-module `lsu_align`: combinational byte-enable generation, store-lane replication, and load extraction/extension; the FSM and timeout counter stay in `lsu`.

## Test plan
- SW addr 0x100, wdata 0xDEADBEEF, `mem_ready` in the first WAIT cycle → `mem_addr`=0x100, `mem_be`=1111, `mem_wdata`=0xDEADBEEF, stall high 2 cycles, DONE in cycle 3.
- SB addr 0x103, wdata 0x000000A5 → `mem_be`=1000, `mem_wdata`=0xA5A5A5A5.
- LB addr 0x102 with `mem_rdata`=0x12F0_3456 → `rdata`=0xFFFFFFF0; LBU same → 0x000000F0; LH addr 0x102 → 0x000012F0.
- `mem_ready` withheld, `TIMEOUT`=4 → 4 WAIT cycles, then DONE with `err`=1, `rdata`=0, `mem_req` low.
- LW addr 0x102 with `LSU_MISALIGN_TRAP_EN` defined → no `mem_req`, DONE next cycle with `err`=1; without the macro → `mem_addr`=0x100, normal load.
- `reset` asserted during WAIT → `mem_req`, `stall` low immediately; IDLE after release.
